// File: rtl/avalon_st_to_sdram_burst_writer_if.sv
// avalon_st_to_sdram_burst_writer_if: instruction/stream/memory/status bundle for the burst writer
interface avalon_st_to_sdram_burst_writer_if #(
  parameter int DATA_W  = 256,
  parameter int ADDR_W  = 27,
  parameter int LEN_W   = 16,
  parameter int BURST_W = 8
);
  logic                    st_instruction_valid;
  logic                    st_instruction_ready;
  logic [LEN_W+ADDR_W-1:0] st_instruction_data;
  logic                    st_valid;
  logic                    st_ready;
  logic [DATA_W-1:0]       st_data;
  logic [ADDR_W-1:0]       mm_addr;
  logic [DATA_W/8-1:0]     mm_byteenable;
  logic [BURST_W-1:0]      mm_burstcount;
  logic                    mm_write;
  logic [DATA_W-1:0]       mm_writedata;
  logic                    mm_waitrequest;
  logic                    busy;
  logic                    done;
  modport master (
    input  st_instruction_valid, st_instruction_data, st_valid, st_data, mm_waitrequest,
    output st_instruction_ready, st_ready, mm_addr, mm_byteenable, mm_burstcount,
           mm_write, mm_writedata, busy, done
  );
  modport slave (
    output st_instruction_valid, st_instruction_data, st_valid, st_data, mm_waitrequest,
    input  st_instruction_ready, st_ready, mm_addr, mm_byteenable, mm_burstcount,
           mm_write, mm_writedata, busy, done
  );
endinterface

// File: rtl/avalon_st_to_sdram_burst_writer.sv
// avalon_st_to_sdram_burst_writer: buffers an instructed number of stream beats and writes them to SDRAM in bursts
module avalon_st_to_sdram_burst_writer #(
  parameter int DATA_W     = 256,
  parameter int ADDR_W     = 27,
  parameter int LEN_W      = 16,
  parameter int BURST_W    = 8,
  parameter int MAX_BURST  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input logic clock,
  input logic reset,
  avalon_st_to_sdram_burst_writer_if.master bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFS   = $clog2(BYTES);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  typedef enum logic [1:0] {IDLE, FILL, BURST, DONE} state_t;
  state_t              r_state, w_next;
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wp, r_rp;
  logic [CW-1:0]       r_count;
  logic [ADDR_W-1:0]   r_cur_addr, r_mm_addr, w_base;
  logic [BURST_W-1:0]  r_mm_burstcount, r_beats_left;
  logic [LEN_W-1:0]    r_in_left, r_out_left, w_blen, w_len;
  logic                w_fire, w_active, w_push, w_pop, w_last, w_issue;
  assign {w_len, w_base} = bus.st_instruction_data;
  assign w_fire   = r_state == IDLE && bus.st_instruction_valid;
  assign w_active = r_state == FILL || r_state == BURST;
  assign w_pop    = r_state == BURST && !bus.mm_waitrequest;
  assign w_last   = w_pop && r_beats_left == BURST_W'(1);
  assign w_blen   = r_out_left < LEN_W'(MAX_BURST) ? r_out_left : LEN_W'(MAX_BURST);
  assign w_issue  = r_state == FILL && LEN_W'(r_count) >= w_blen;
  // a full FIFO can still take a beat in the cycle the head is written out
  assign bus.st_ready = w_active && r_in_left != '0 && (r_count != CW'(FIFO_DEPTH) || w_pop);
  assign w_push   = bus.st_valid && bus.st_ready;
  assign bus.st_instruction_ready = r_state == IDLE;
  assign bus.mm_write      = r_state == BURST;
  assign bus.mm_byteenable = {BYTES{bus.mm_write}};
  assign bus.mm_writedata  = bus.mm_write ? r_mem[r_rp] : '0;
  assign bus.mm_addr       = r_mm_addr;
  assign bus.mm_burstcount = r_mm_burstcount;
  assign bus.busy = r_state != IDLE;
  assign bus.done = r_state == DONE;
  // state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  // next state: a burst is only issued once all of its beats are buffered, so it never stalls mid-burst
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_fire ? (w_len == '0 ? DONE : FILL) : IDLE;
      FILL:    w_next = w_issue ? BURST : FILL;
      BURST:   w_next = w_last ? (r_out_left == LEN_W'(1) ? DONE : FILL) : BURST;
      default: w_next = IDLE;
    endcase
  end
  // counters, FIFO pointers and burst address/count registers
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_wp            <= '0;
      r_rp            <= '0;
      r_count         <= '0;
      r_cur_addr      <= '0;
      r_mm_addr       <= '0;
      r_mm_burstcount <= '0;
      r_beats_left    <= '0;
      r_in_left       <= '0;
      r_out_left      <= '0;
    end else begin
      if (w_fire) begin
        r_cur_addr <= w_base & ~ADDR_W'(BYTES - 1);
        r_in_left  <= w_len;
        r_out_left <= w_len;
      end
      if (w_push) begin
        r_in_left <= r_in_left - LEN_W'(1);
        r_wp      <= r_wp + AW'(1);
      end
      if (w_issue) begin
        r_mm_addr       <= r_cur_addr;
        r_mm_burstcount <= BURST_W'(w_blen);
        r_beats_left    <= BURST_W'(w_blen);
      end
      if (w_pop) begin
        r_rp         <= r_rp + AW'(1);
        r_out_left   <= r_out_left - LEN_W'(1);
        r_beats_left <= r_beats_left - BURST_W'(1);
      end
      if (w_last) r_cur_addr <= r_cur_addr + (ADDR_W'(r_mm_burstcount) << OFS);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  // beat storage; contents are meaningless once the pointers are reset
  always_ff @(posedge clock)
    if (w_push) r_mem[r_wp] <= bus.st_data;
endmodule
